sd_spi_init_ctrl: RTL and testbench

SD_SPI_INIT_CTRL -- requirements
Module: sd_spi_init_ctrl

---
 rtl/sd_spi_init_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_sd_spi_init_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_init_ctrl.sv
// sd_spi_init_ctrl: SPI-mode SD card power-up and identification sequencer.
// Issues CMD0/CMD8/CMD55/ACMD41/CMD58 and reports card type or failure cause.
module sd_spi_init_ctrl #(
  parameter int CLK_DIV     = 100,
  parameter int INIT_CYCLES = 80,
  parameter int NCR_MAX     = 8,
  parameter int MAX_RETRY   = 1000
) (
  input  logic        input_clk,
  input  logic        input_rst_n,
  input  logic        start,
  input  logic        MISO_bit,
  output logic        sclk,
  output logic        CS_bit,
  output logic        MOSI_bit,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        card_hc,
  output logic        card_v2,
  output logic [15:0] response
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_POWERUP = 4'd1;
  localparam logic [3:0] S_SEND    = 4'd2;
  localparam logic [3:0] S_WAIT_R1 = 4'd3;
  localparam logic [3:0] S_TAIL    = 4'd4;
  localparam logic [3:0] S_GAP     = 4'd5;
  localparam logic [3:0] S_EVAL    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  localparam logic [2:0] C_CMD0   = 3'd0;
  localparam logic [2:0] C_CMD8   = 3'd1;
  localparam logic [2:0] C_CMD55  = 3'd2;
  localparam logic [2:0] C_ACMD41 = 3'd3;
  localparam logic [2:0] C_CMD58  = 3'd4;

  localparam logic [2:0] E_NONE  = 3'b000;
  localparam logic [2:0] E_NCR   = 3'b001;
  localparam logic [2:0] E_CMD0  = 3'b010;
  localparam logic [2:0] E_ECHO  = 3'b011;
  localparam logic [2:0] E_RETRY = 3'b100;
  localparam logic [2:0] E_R1    = 3'b101;

  localparam int NPOLL = NCR_MAX * 8;
  localparam int CW    = $clog2(INIT_CYCLES + NPOLL + 64);
  localparam int DW    = $clog2(CLK_DIV + 1);
  localparam int RW    = $clog2(MAX_RETRY + 1);

  logic [3:0]    state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          miso_q, miso_d;
  logic          sb_q, sb_d;
  logic [7:0]    r1_q, r1_d;
  logic [31:0]   tail_q, tail_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [2:0]    code_q, code_d;
  logic          hc_q, hc_d;
  logic          v2_q, v2_d;
  logic [15:0]   resp_q, resp_d;

  logic          run;
  logic          tick;
  logic          rise;
  logic          fall;
  logic          quiet_d;
  logic          fail;
  logic          fin;
  logic [2:0]    fcode;
  logic [7:0]    r1_nx;
  logic [5:0]    bidx;
  logic [47:0]   frame;

  function automatic logic [47:0] frame_of(
    input logic [2:0] c,
    input logic       hcs
  );
    logic [47:0] f;
    f = 48'h400000000095;
    unique case (c)
      C_CMD0:   f = 48'h400000000095;
      C_CMD8:   f = 48'h48000001AA87;
      C_CMD55:  f = 48'h7700000000FF;
      C_ACMD41: f = {8'h69, 1'b0, hcs, 30'd0, 8'hFF};
      C_CMD58:  f = 48'h7A00000000FF;
      default:  f = 48'h400000000095;
    endcase
    return f;
  endfunction

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    retry_d = retry_q;
    sclk_d  = sclk_q;
    miso_d  = miso_q;
    sb_d    = sb_q;
    r1_d    = r1_q;
    tail_d  = tail_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    hc_d    = hc_q;
    v2_d    = v2_q;
    resp_d  = resp_q;
    fail    = 1'b0;
    fin     = 1'b0;
    fcode   = E_NONE;

    frame = frame_of(cmd_q, v2_q);
    r1_nx = {r1_q[6:0], miso_q};
    bidx  = 6'd47 - cnt_q[5:0];

    run  = (state_q == S_POWERUP) || (state_q == S_SEND) ||
           (state_q == S_WAIT_R1) || (state_q == S_TAIL) ||
           (state_q == S_GAP);
    tick = run && (div_q == DW'(CLK_DIV - 1));
    rise = tick && !sclk_q;
    fall = tick && sclk_q;

    if (run) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) sclk_d = ~sclk_q;
    end
    if (rise) miso_d = MISO_bit;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        sclk_d = 1'b0;
        if (start) begin
          state_d = S_POWERUP;
          cmd_d   = C_CMD0;
          cnt_d   = '0;
          div_d   = '0;
          retry_d = '0;
          sb_d    = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = E_NONE;
          hc_d    = 1'b0;
          v2_d    = 1'b0;
        end
      end
      S_POWERUP: if (fall) begin
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: if (fall) begin
        if (cnt_q == CW'(47)) begin
          state_d = S_WAIT_R1;
          cnt_d   = '0;
          sb_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_R1: if (fall) begin
        if (!sb_q) begin
          // the first 0 seen on MISO is bit 7 of R1
          if (!miso_q) begin
            sb_d  = 1'b1;
            r1_d  = r1_nx;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(NPOLL - 1)) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = E_NCR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          r1_d = r1_nx;
          if (cnt_q == CW'(7)) begin
            cnt_d = '0;
            if ((cmd_q == C_CMD58) ||
                ((cmd_q == C_CMD8) && (r1_nx == 8'h01)))
              state_d = S_TAIL;
            else
              state_d = S_EVAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_TAIL: if (fall) begin
        tail_d = {tail_q[30:0], miso_q};
        if (cnt_q == CW'(31)) begin
          state_d = S_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EVAL: begin
        resp_d  = {frame[47:40], r1_q};
        state_d = S_GAP;
        cnt_d   = '0;
        unique case (cmd_q)
          C_CMD0: begin
            if (r1_q == 8'h01) cmd_d = C_CMD8;
            else begin fail = 1'b1; fcode = E_CMD0; end
          end
          C_CMD8: begin
            if (r1_q == 8'h01) begin
              if (tail_q[11:0] == 12'h1AA) begin
                v2_d  = 1'b1;
                cmd_d = C_CMD55;
              end else begin
                fail  = 1'b1;
                fcode = E_ECHO;
              end
            end else if (r1_q[2]) begin
              cmd_d = C_CMD55;
            end else begin
              fail  = 1'b1;
              fcode = E_R1;
            end
          end
          C_CMD55: begin
            if (r1_q[7:1] != 7'd0) begin
              fail  = 1'b1;
              fcode = E_R1;
            end else begin
              cmd_d = C_ACMD41;
            end
          end
          C_ACMD41: begin
            if (r1_q == 8'h00) begin
              if (v2_q) cmd_d = C_CMD58;
              else      fin   = 1'b1;
            end else if (r1_q == 8'h01) begin
              if (retry_q != RW'(MAX_RETRY))
                retry_d = retry_q + 1'b1;
              if (retry_q >= RW'(MAX_RETRY - 1)) begin
                fail  = 1'b1;
                fcode = E_RETRY;
              end else begin
                cmd_d = C_CMD55;
              end
            end else begin
              fail  = 1'b1;
              fcode = E_R1;
            end
          end
          C_CMD58: begin
            if (r1_q == 8'h00) begin
              hc_d = tail_q[30];
              fin  = 1'b1;
            end else begin
              fail  = 1'b1;
              fcode = E_R1;
            end
          end
          default: begin
            fail  = 1'b1;
            fcode = E_R1;
          end
        endcase
        if (fail) begin
          state_d = S_ERR;
          error_d = 1'b1;
          code_d  = fcode;
        end else if (fin) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_GAP: if (fall) begin
        if (cnt_q == CW'(7)) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // pins lag the state by one clock so MOSI moves just after SCLK falls
    quiet_d = (state_d == S_IDLE) || (state_d == S_DONE) ||
              (state_d == S_ERR);
    busy_d  = !quiet_d;
    cs_d    = 1'b1;
    mosi_d  = 1'b1;
    if (!quiet_d) begin
      cs_d   = !((state_q == S_SEND) || (state_q == S_WAIT_R1) ||
                 (state_q == S_TAIL));
      mosi_d = (state_q == S_SEND) ? frame[bidx] : 1'b1;
    end
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= C_CMD0;
      cnt_q   <= '0;
      div_q   <= '0;
      retry_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b1;
      miso_q  <= 1'b1;
      sb_q    <= 1'b0;
      r1_q    <= 8'h00;
      tail_q  <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= E_NONE;
      hc_q    <= 1'b0;
      v2_q    <= 1'b0;
      resp_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      retry_q <= retry_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      miso_q  <= miso_d;
      sb_q    <= sb_d;
      r1_q    <= r1_d;
      tail_q  <= tail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      hc_q    <= hc_d;
      v2_q    <= v2_d;
      resp_q  <= resp_d;
    end
  end

  assign sclk     = sclk_q;
  assign CS_bit   = cs_q;
  assign MOSI_bit = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = code_q;
  assign card_hc  = hc_q;
  assign card_v2  = v2_q;
  assign response = resp_q;

endmodule

// File: tb/tb_sd_spi_init_ctrl.sv
// tb_sd_spi_init_ctrl: scoreboard bench with a behavioural SPI-mode SD card.
// Stimulus queues expected frames/status; one monitor retires and compares.
`timescale 1ns/1ps
module tb_sd_spi_init_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int INIT_CYCLES = 74;
  localparam int NCR_MAX     = 2;
  localparam int MAX_RETRY   = 4;
  localparam int BOUND       = 15000;

  localparam logic [47:0] F0   = 48'h400000000095;
  localparam logic [47:0] F8   = 48'h48000001AA87;
  localparam logic [47:0] F55  = 48'h7700000000FF;
  localparam logic [47:0] F41H = 48'h6940000000FF;
  localparam logic [47:0] F41L = 48'h6900000000FF;
  localparam logic [47:0] F58  = 48'h7A00000000FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        miso = 1'b1;
  logic        sclk, cs, mosi, busy, done, error;
  logic        card_hc, card_v2;
  logic [2:0]  err_code;
  logic [15:0] response;

  sd_spi_init_ctrl #(
    .CLK_DIV(CLK_DIV), .INIT_CYCLES(INIT_CYCLES),
    .NCR_MAX(NCR_MAX), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .input_clk(clk), .input_rst_n(rst_n), .start(start),
    .MISO_bit(miso), .sclk(sclk), .CS_bit(cs), .MOSI_bit(mosi),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .card_hc(card_hc), .card_v2(card_v2), .response(response)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  logic [47:0] exp_f[$];
  logic [47:0] got_f[$];
  logic [25:0] exp_s[$];
  chk_t        chk_q[$];
  int          checks = 0;
  int          errors = 0;
  int          scn = 0;
  int          run_id = 0;

  function automatic logic [25:0] st(input logic d, input logic e,
                                     input logic [2:0] c, input logic hc,
                                     input logic v2, input logic [15:0] r);
    return {d, e, c, hc, v2, r, 1'b1, 1'b1, 1'b0};
  endfunction

  // ---------------- card model ----------------
  int          blk_run = -1;
  int          nfr = 0;
  int          bitn = 0;
  int          pu_cnt = 0;
  int          post_cnt = 0;
  int          a41 = 0;
  int          dly = 0;
  int          rlen = 0;
  logic        inf = 1'b0;
  logic [47:0] sh = '0;
  logic [47:0] rbits = '0;

  always @(posedge sclk or negedge sclk or posedge cs) begin
    if (blk_run != run_id) begin
      blk_run  = run_id;
      nfr      = 0;
      pu_cnt   = 0;
      post_cnt = 0;
      a41      = 0;
    end
    if (cs) begin
      if (sclk && nfr == 0) pu_cnt++;
      inf  = 1'b0;
      bitn = 0;
      dly  = 0;
      rlen = 0;
      miso = 1'b1;
    end else if (sclk) begin
      if (!inf) begin
        if (mosi == 1'b0) begin
          inf  = 1'b1;
          bitn = 1;
          sh   = {sh[46:0], mosi};
        end else begin
          post_cnt++;
        end
      end else begin
        sh = {sh[46:0], mosi};
        bitn++;
        if (bitn == 48) begin
          inf = 1'b0;
          got_f.push_back(sh);
          nfr++;
          post_cnt = 0;
          dly  = 8;
          rlen = 8;
          case (sh[47:40])
            8'h40: begin
              rbits = {8'h01, 40'h0};
              if (scn == 2) rlen = 0;
            end
            8'h48: begin
              if (scn == 1) begin
                rbits = {8'h05, 40'h0};
              end else begin
                rlen = 40;
                if (scn == 4) rbits = {8'h01, 32'h000001AB, 8'h0};
                else          rbits = {8'h01, 32'h000001AA, 8'h0};
              end
            end
            8'h77: rbits = {8'h01, 40'h0};
            8'h69: begin
              a41++;
              if ((scn == 0 && a41 >= 3) || scn == 1)
                rbits = {8'h00, 40'h0};
              else
                rbits = {8'h01, 40'h0};
            end
            8'h7A: begin
              rlen  = 40;
              rbits = {8'h00, 32'hC0FF8000, 8'h0};
            end
            default: rlen = 0;
          endcase
        end
      end
    end else begin
      if (dly > 0) begin
        dly--;
        miso = 1'b1;
      end else if (rlen > 0) begin
        miso  = rbits[47];
        rbits = {rbits[46:0], 1'b1};
        rlen--;
      end else begin
        miso = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        busy_p = 1'b0;
  logic [47:0] mf, ef;
  logic [25:0] as, es;
  chk_t        ck;

  always @(negedge clk) begin
    while (got_f.size() > 0) begin
      mf = got_f.pop_front();
      checks++;
      if (exp_f.size() == 0) begin
        errors++;
        $display("FAIL frame: got %h, required none", mf);
      end else begin
        ef = exp_f.pop_front();
        if (mf !== ef) begin
          errors++;
          $display("FAIL frame: got %h, required %h", mf, ef);
        end
      end
    end
    if (busy_p && !busy) begin
      as = {done, error, err_code, card_hc, card_v2, response,
            cs, mosi, sclk};
      checks++;
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL status: got %h, required none", as);
      end else begin
        es = exp_s.pop_front();
        if (as !== es) begin
          errors++;
          $display("FAIL status: got %h, required %h", as, es);
        end
      end
    end
    busy_p = busy;
    while (chk_q.size() > 0) begin
      ck = chk_q.pop_front();
      checks++;
      if (ck.act != ck.exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d",
                 ck.name, ck.act, ck.exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic add_chk(input string n, input int a, input int e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string nm);
    int k;
    k = 0;
    while (!(blk_run == run_id && nfr >= n) && k < BOUND) begin
      @(posedge clk);
      k++;
    end
    if (k >= BOUND) add_chk({nm, "_wait"}, 1, 0);
  endtask

  task automatic run_scn(input int s, input string nm, input bit poke);
    int k;
    scn = s;
    run_id++;
    pulse_start();
    @(negedge clk);
    add_chk({nm, "_busy"}, int'(busy), 1);
    if (poke) begin
      wait_frames(1, nm);
      pulse_start();
    end
    k = 0;
    while (busy && k < BOUND) begin
      @(posedge clk);
      k++;
    end
    if (k >= BOUND) add_chk({nm, "_timeout"}, 1, 0);
    repeat (4) @(posedge clk);
    add_chk({nm, "_left"}, exp_f.size() + exp_s.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    add_chk("rst_cs", int'(cs), 1);
    add_chk("rst_resp", int'(response), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    add_chk("idle_busy", int'(busy), 0);
    add_chk("idle_sclk", int'(sclk), 0);

    // reset pulsed in the middle of the CMD8 frame
    scn = 0;
    run_id++;
    exp_f.push_back(F0);
    exp_s.push_back(26'b0 | {16'h0, 3'b110});
    pulse_start();
    wait_frames(1, "midrst");
    while (!(inf && bitn >= 20) && scn == 0 && nfr < 2 && busy)
      @(posedge clk);
    #3 rst_n = 1'b0;
    #2;
    add_chk("midrst_sclk", int'(sclk), 0);
    add_chk("midrst_cs", int'(cs), 1);
    add_chk("midrst_mosi", int'(mosi), 1);
    add_chk("midrst_busy", int'(busy), 0);
    add_chk("midrst_resp", int'(response), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    add_chk("midrst_idle", int'(busy), 0);
    add_chk("midrst_left", exp_f.size() + exp_s.size(), 0);

    // SDHC card
    exp_f.push_back(F0);
    exp_f.push_back(F8);
    repeat (3) begin
      exp_f.push_back(F55);
      exp_f.push_back(F41H);
    end
    exp_f.push_back(F58);
    exp_s.push_back(st(1, 0, 3'b000, 1, 1, 16'h7A00));
    run_scn(0, "sdhc", 0);
    add_chk("sdhc_powerup", pu_cnt, INIT_CYCLES);
    add_chk("sdhc_acmd41", a41, 3);

    // v1 card rejects CMD8
    exp_f.push_back(F0);
    exp_f.push_back(F8);
    exp_f.push_back(F55);
    exp_f.push_back(F41L);
    exp_s.push_back(st(1, 0, 3'b000, 0, 0, 16'h6900));
    run_scn(1, "v1", 0);

    // ACMD41 never leaves idle
    exp_f.push_back(F0);
    exp_f.push_back(F8);
    repeat (4) begin
      exp_f.push_back(F55);
      exp_f.push_back(F41H);
    end
    exp_s.push_back(st(0, 1, 3'b100, 0, 1, 16'h6901));
    run_scn(3, "retry", 0);
    add_chk("retry_acmd41", a41, 4);

    // bad CMD8 echo, with a start pulse while busy
    exp_f.push_back(F0);
    exp_f.push_back(F8);
    exp_s.push_back(st(0, 1, 3'b011, 0, 0, 16'h4801));
    run_scn(4, "echo", 1);

    // no response to CMD0; response keeps the previous value
    exp_f.push_back(F0);
    exp_s.push_back(st(0, 1, 3'b001, 0, 0, 16'h4801));
    run_scn(2, "ncr", 0);
    add_chk("ncr_polls", post_cnt, NCR_MAX * 8);

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
